// File: rtl/w_seq_pkg.sv
// Shared types and defaults for the w/z detector word scheduler.
package w_seq_pkg;

    localparam int unsigned W_SEQ_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        SHIFT,
        DRAIN,
        RESP
    } w_seq_state_e;

endpackage

// File: rtl/w_seq_scheduler.sv
// Shifts accepted words LSB-first into a serial w/z detector and returns a per-bit hit mask and count.
// Optional W_SEQ_ABORT_EN adds an abort input that cancels an in-flight job.
module w_seq_scheduler
    import w_seq_pkg::*;
#(
    parameter  int unsigned WIDTH = W_SEQ_WIDTH,
    localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_word,
    output logic             det_rst,
    output logic             det_w,
    input  logic             det_z,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_mask,
    output logic [CNT_W-1:0] out_count
`ifdef W_SEQ_ABORT_EN
    ,
    input  logic             abort
`endif
);

    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    w_seq_state_e      state;
    logic [IDX_W-1:0]  idx;
    logic [WIDTH-1:0]  word;

    // det_z lags det_w by one cycle, so bit k is scored while bit k+1 is driven
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            word      <= '0;
            out_mask  <= '0;
            out_count <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            det_rst   <= 1'b0;
            det_w     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        word      <= in_word;
                        out_mask  <= '0;
                        out_count <= '0;
                        in_ready  <= 1'b0;
                        det_rst   <= 1'b1;
                        det_w     <= 1'b0;
                        state     <= CLR;
                    end
                end
                CLR: begin
                    det_rst <= 1'b0;
                    idx     <= '0;
                    det_w   <= word[0];
                    state   <= SHIFT;
                end
                SHIFT: begin
                    if (idx != '0) begin
                        out_mask[idx - IDX_W'(1)] <= det_z;
                        if (det_z) out_count <= out_count + CNT_W'(1);
                    end
                    if (idx == LAST_IDX) begin
                        det_w <= 1'b0;
                        state <= DRAIN;
                    end else begin
                        idx   <= idx + IDX_W'(1);
                        det_w <= word[idx + IDX_W'(1)];
                    end
                end
                DRAIN: begin
                    out_mask[WIDTH-1] <= det_z;
                    if (det_z) out_count <= out_count + CNT_W'(1);
                    out_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    idx       <= '0;
                    out_mask  <= '0;
                    out_count <= '0;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    det_rst   <= 1'b0;
                    det_w     <= 1'b0;
                    state     <= IDLE;
                end
            endcase
`ifdef W_SEQ_ABORT_EN
            // Abort only cancels work in flight; an idle or completed job is left alone
            if (abort && (state == CLR || state == SHIFT || state == DRAIN)) begin
                idx       <= '0;
                out_mask  <= '0;
                out_count <= '0;
                in_ready  <= 1'b1;
                out_valid <= 1'b0;
                det_rst   <= 1'b0;
                det_w     <= 1'b0;
                state     <= IDLE;
            end
`endif
        end
    end

endmodule
